// File: rtl/lcd_num_fmt.sv
// Binary-to-ASCII decimal formatter feeding a PCD8544-class display engine.
// Emits one set-position token, then NDIG characters MSD first, on a valid/ready stream.
module lcd_num_fmt #(
    parameter int unsigned DW         = 16,
    parameter int unsigned NDIG       = 5,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          num_valid,
    output logic          num_ready,
    input  logic [DW-1:0] num_data,
    input  logic [2:0]    num_y,
    input  logic [6:0]    num_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_kind,
    output logic [2:0]    out_y,
    output logic [6:0]    out_x,
    output logic [7:0]    out_char,
    output logic          busy
);

    localparam int unsigned BW = NDIG * 4;
    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned IW = $clog2(NDIG + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    if (pow10(NDIG) <= ((64'd1 << DW) - 64'd1)) begin : g_bad_ndig
        $error("lcd_num_fmt: NDIG too small to hold 2^DW-1");
    end

    typedef enum logic [1:0] {IDLE, CONV, POS, CHAR} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] bin_q, bin_d;
    logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          blank_q, blank_d;
    logic [2:0]    y_q, y_d;
    logic [6:0]    x_q, x_d;
    logic          out_valid_q, out_valid_d;
    logic          out_kind_q, out_kind_d;
    logic [2:0]    out_y_q, out_y_d;
    logic [6:0]    out_x_q, out_x_d;
    logic [7:0]    out_char_q, out_char_d;
    logic [3:0]    nib_cur, nib_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            blank_q     <= 1'b0;
            y_q         <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_y_q     <= '0;
            out_x_q     <= '0;
            out_char_q  <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            y_q         <= y_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_y_q     <= out_y_d;
            out_x_q     <= out_x_d;
            out_char_q  <= out_char_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (num_valid) state_d = CONV;
            CONV: if (cnt_q == CW'(DW - 1)) state_d = POS;
            POS:  if (out_ready) state_d = CHAR;
            CHAR: if (out_ready && idx_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    assign nib_cur = bcd_q[idx_q*4 +: 4];

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        y_d     = y_q;
        x_d     = x_q;
        case (state_q)
            IDLE: if (num_valid) begin
                bin_d = num_data;
                y_d   = num_y;
                x_d   = num_x;
                bcd_d = '0;
                cnt_d = '0;
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
            end
            POS: if (out_ready) begin
                idx_d   = IW'(NDIG - 1);
                blank_d = LEAD_BLANK;
            end
            CHAR: if (out_ready && idx_q != '0) begin
                idx_d   = idx_q - 1'b1;
                blank_d = blank_q && (nib_cur == 4'd0);
            end
            default: ;
        endcase
    end

    // Outputs are precomputed from the next state so the token is registered and
    // naturally holds while a stall keeps state/index/blank unchanged.
    assign nib_nxt = bcd_q[idx_d*4 +: 4];

    always_comb begin
        out_valid_d = (state_d == POS) || (state_d == CHAR);
        out_kind_d  = (state_d == CHAR);
        out_y_d     = out_y_q;
        out_x_d     = out_x_q;
        out_char_d  = out_char_q;
        if (state_d == POS) begin
            out_y_d = y_q;
            out_x_d = x_q;
        end
        if (state_d == CHAR) begin
            if (blank_d && nib_nxt == 4'd0 && idx_d != '0) out_char_d = 8'h20;
            else out_char_d = 8'h30 + {4'h0, nib_nxt};
        end
    end

    assign num_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_y     = out_y_q;
    assign out_x     = out_x_q;
    assign out_char  = out_char_q;

endmodule

// File: tb/tb_lcd_num_fmt.sv
// Directed bench for lcd_num_fmt: two lock-stepped instances (LEAD_BLANK=1 and 0)
// share all inputs; sel picks which one's outputs are observed.
module tb_lcd_num_fmt;

    logic        clk = 1'b0;
    logic        rst, num_valid, out_ready, sel;
    logic [15:0] num_data;
    logic [2:0]  num_y;
    logic [6:0]  num_x;

    logic       a_ready, a_valid, a_kind, a_busy;
    logic [2:0] a_y;
    logic [6:0] a_x;
    logic [7:0] a_char;
    logic       b_ready, b_valid, b_kind, b_busy;
    logic [2:0] b_y;
    logic [6:0] b_x;
    logic [7:0] b_char;

    logic       o_ready, o_valid, o_kind, o_busy;
    logic [2:0] o_y;
    logic [6:0] o_x;
    logic [7:0] o_char;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_num_fmt #(.DW(16), .NDIG(5), .LEAD_BLANK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .num_valid(num_valid), .num_ready(a_ready),
        .num_data(num_data), .num_y(num_y), .num_x(num_x),
        .out_valid(a_valid), .out_ready(out_ready), .out_kind(a_kind),
        .out_y(a_y), .out_x(a_x), .out_char(a_char), .busy(a_busy)
    );

    lcd_num_fmt #(.DW(16), .NDIG(5), .LEAD_BLANK(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .num_valid(num_valid), .num_ready(b_ready),
        .num_data(num_data), .num_y(num_y), .num_x(num_x),
        .out_valid(b_valid), .out_ready(out_ready), .out_kind(b_kind),
        .out_y(b_y), .out_x(b_x), .out_char(b_char), .busy(b_busy)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_kind  = sel ? b_kind  : a_kind;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_y     = sel ? b_y     : a_y;
    assign o_x     = sel ? b_x     : a_x;
    assign o_char  = sel ? b_char  : a_char;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_tok"},   32'({o_kind, o_y, o_x, o_char}), 32'd0);
    endtask

    // Inputs change and outputs are sampled on the negedge; c counts cycles
    // from the accept cycle (c=0).
    task automatic run(input string tag, input logic [15:0] v, input logic [2:0] y,
                       input logic [6:0] x, input logic [39:0] exp, input bit rnd,
                       input bit pre, input bit keep, input logic [15:0] kv, input bit lat);
        int          c, ntok, first, g;
        bit          stalled;
        logic [18:0] prev, cur;
        logic [18:0] tok [6];
        for (int i = 0; i < 6; i++) tok[i] = '0;
        prev = '0;
        if (!pre) begin
            g = 0;
            @(negedge clk);
            while (!o_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            chk({tag, "_idle"}, 32'(o_ready), 32'd1);
            num_data  = v;
            num_y     = y;
            num_x     = x;
            num_valid = 1'b1;
        end
        c = 0;
        @(negedge clk);
        c = 1;
        if (keep) num_data = kv;
        else num_valid = 1'b0;
        ntok = 0;
        first = -1;
        stalled = 1'b0;
        while (ntok < 6 && c < 200) begin
            cur = {o_kind, o_y, o_x, o_char};
            if (o_valid && first < 0) first = c;
            if (stalled) begin
                chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
                chk({tag, "_hold_tok"}, 32'(cur), 32'(prev));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && out_ready) begin
                tok[ntok] = cur;
                ntok++;
                stalled = 1'b0;
            end else begin
                stalled = o_valid;
            end
            prev = cur;
            @(negedge clk);
            c++;
        end
        out_ready = 1'b1;
        chk({tag, "_ntok"}, 32'(ntok), 32'd6);
        chk({tag, "_pos"}, 32'(tok[0][18:8]), 32'({1'b0, y, x}));
        for (int i = 1; i < 6; i++)
            chk({tag, "_char"}, 32'({tok[i][18], tok[i][7:0]}), 32'({1'b1, exp[(5-i)*8 +: 8]}));
        while (!o_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done"}, 32'(o_ready), 32'd1);
        if (lat) begin
            chk({tag, "_lat_valid"}, 32'(first), 32'd17);
            chk({tag, "_lat_ready"}, 32'(c), 32'd23);
        end
    endtask

    task automatic watch_quiet(input string tag);
        int nv;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_valid || o_busy) nv++;
        end
        chk({tag, "_quiet"}, 32'(nv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst       = 1'b1;
        num_valid = 1'b0;
        num_data  = '0;
        num_y     = '0;
        num_x     = '0;
        out_ready = 1'b1;
        sel       = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;

        run("basic", 16'd12345, 3'd3, 7'd6, "12345", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        run("zero",  16'd0,     3'd0, 7'd0, "    0", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        run("v42",   16'd42,    3'd5, 7'd83, "   42", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        sel = 1'b1;
        run("nb42",  16'd42,    3'd1, 7'd10, "00042", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        sel = 1'b0;
        run("max",   16'd65535, 3'd2, 7'd40, "65535", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        run("izero", 16'd40960, 3'd4, 7'd12, "40960", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        run("bp907", 16'd907,   3'd1, 7'd30, "  907", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        run("b111",  16'd111,   3'd2, 7'd18, "  111", 1'b0, 1'b0, 1'b1, 16'd222, 1'b0);
        run("b222",  16'd222,   3'd2, 7'd18, "  222", 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);

        // Reset while converting.
        @(negedge clk);
        num_data  = 16'd999;
        num_y     = 3'd3;
        num_x     = 7'd50;
        num_valid = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("conv_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_conv");
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("rst_conv");

        // Reset while the third character token is offered.
        @(negedge clk);
        num_data  = 16'd65535;
        num_valid = 1'b1;
        c = 0;
        @(negedge clk);
        num_valid = 1'b0;
        c = 1;
        while (c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("char3_tok", 32'({o_valid, o_kind, o_char}), 32'({1'b1, 1'b1, 8'h35}));
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_char");
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("rst_char");

        run("post5", 16'd5, 3'd0, 7'd78, "    5", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
